controller: RTL and testbench

- Multicycle MIPS main control FSM. It sits directly upstream of the datapath.
- Consumes the latched opcode `op` from the datapath and produces every datapath control strobe, one state per cycle.
- Also drives the memory read/write strobes, the 2-bit ALUOp to the ALU controller, a retired-instruction counter and an illegal-opcode pulse.

---
 rtl/mips_defs.sv | 67 ++++++
 rtl/ctrl_outdec.sv | 75 +++++++
 rtl/controller.sv | 111 +++++++++++
 tb/tb_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS datapath, ALU controller and main controller.
package mips_defs;

  // Opcodes decoded by the main controller (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Main FSM states; the encodings are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // ALUOp codes sent to the ALU controller
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-PC select codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select codes
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Bundle of all datapath strobes produced by the output decoder
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrlSig_t;

  // States whose exit to FETCH marks an instruction as retired
  function automatic logic isRetireState(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTYPEWB) ||
           (s == S_BEQEX) || (s == S_ADDIWB) || (s == S_JEX);
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational Moore decode of the controller state into datapath strobes.
// Only the FETCH strobes that commit the fetched word depend on memReady.
module ctrl_outdec
  import mips_defs::*;
(
  input  state_t   state,
  input  logic     memReady,
  output ctrlSig_t ctrl
);

  // Per-state strobe table; anything not set stays 0 (covers unreachable codes)
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iorD    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iorD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REGB;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REGB;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regWrite = 1'b1;
      end
      S_JEX: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// retired-instruction counter. Strobes come from ctrl_outdec and are forced
// to 0 while reset is high so no partial access leaks out after a reset edge.
module controller
  import mips_defs::*;
#(
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instrCount
);

  state_t   curState;
  state_t   nextState;
  logic     illegalDec;
  ctrlSig_t decSig;
  ctrlSig_t outSig;

  ctrl_outdec uOutdec (
    .state    (curState),
    .memReady (memReady),
    .ctrl     (decSig)
  );

  // State register, reset straight back to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) curState <= S_FETCH;
    else       curState <= nextState;
  end

  // Next-state selection; unknown opcodes in DECODE abandon the instruction
  always_comb begin
    nextState  = S_FETCH;
    illegalDec = 1'b0;
    case (curState)
      S_FETCH:   nextState = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nextState = S_MEMADR;
          OP_RTYPE:     nextState = S_RTYPEEX;
          OP_BEQ:       nextState = S_BEQEX;
          OP_ADDI:      nextState = S_ADDIEX;
          OP_J:         nextState = S_JEX;
          default: begin
            nextState  = S_FETCH;
            illegalDec = 1'b1;
          end
        endcase
      end
      S_MEMADR:  nextState = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nextState = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nextState = S_FETCH;
      S_MEMWR:   nextState = memReady ? S_FETCH : S_MEMWR;
      S_RTYPEEX: nextState = S_RTYPEWB;
      S_RTYPEWB: nextState = S_FETCH;
      S_BEQEX:   nextState = S_FETCH;
      S_ADDIEX:  nextState = S_ADDIWB;
      S_ADDIWB:  nextState = S_FETCH;
      S_JEX:     nextState = S_FETCH;
      default:   nextState = S_FETCH;
    endcase
  end

  // Count an instruction each time a final state hands back to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instrCount <= '0;
    else if (isRetireState(curState) && (nextState == S_FETCH))
      instrCount <= instrCount + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Silence every strobe while reset is held
  always_comb begin
    outSig = reset ? '0 : decSig;
  end

  assign PCWrite     = outSig.pcWrite;
  assign PCWriteCond = outSig.pcWriteCond;
  assign PCSource    = outSig.pcSource;
  assign IorD        = outSig.iorD;
  assign MemRead     = outSig.memRead;
  assign MemWrite    = outSig.memWrite;
  assign MemToReg    = outSig.memToReg;
  assign IRWrite     = outSig.irWrite;
  assign RegWrite    = outSig.regWrite;
  assign RegDst      = outSig.regDst;
  assign ALUSrcA     = outSig.aluSrcA;
  assign ALUSrcB     = outSig.aluSrcB;
  assign ALUOp       = outSig.aluOp;
  assign illegal     = illegalDec & ~reset;
  assign state       = curState;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the main controller: the driver queues the expected
// state, strobes and counters for each cycle; a monitor pops and compares.
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memReady;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic        IRWrite, RegWrite, RegDst, ALUSrcA, illegal;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] instrCount;

  logic        w2PCWrite, w2PCWriteCond, w2IorD, w2MemRead, w2MemWrite, w2MemToReg;
  logic        w2IRWrite, w2RegWrite, w2RegDst, w2ALUSrcA, w2illegal;
  logic [1:0]  w2PCSource, w2ALUSrcB, w2ALUOp;
  logic [3:0]  w2state;
  logic [1:0]  w2instrCount;

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    int          st;
    logic [16:0] ctl;
    int          cnt;
  } expEntry_t;

  expEntry_t expQ[$];

  controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal(illegal), .state(state), .instrCount(instrCount)
  );

  controller #(.CNT_W(2)) dutNarrow (
    .clk(clk), .reset(reset), .op(op), .memReady(memReady),
    .PCWrite(w2PCWrite), .PCWriteCond(w2PCWriteCond), .PCSource(w2PCSource),
    .IorD(w2IorD), .MemRead(w2MemRead), .MemWrite(w2MemWrite), .MemToReg(w2MemToReg),
    .IRWrite(w2IRWrite), .RegWrite(w2RegWrite), .RegDst(w2RegDst),
    .ALUSrcA(w2ALUSrcA), .ALUSrcB(w2ALUSrcB), .ALUOp(w2ALUOp),
    .illegal(w2illegal), .state(w2state), .instrCount(w2instrCount)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Expected strobes per state, taken from the state table
  function automatic logic [16:0] expCtrl(input int s, input logic mr, input logic ill);
    logic pcw, pcwc, iord, mrd, mw, mtr, irw, rw, rd, sa, il;
    logic [1:0] pcs, sb, aop;
    {pcw, pcwc, iord, mrd, mw, mtr, irw, rw, rd, sa, il} = '0;
    pcs = 2'b00; sb = 2'b00; aop = 2'b00;
    case (s)
      0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  begin sb = 2'b11; il = ill; end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin iord = 1'b1; mrd = 1'b1; end
      4:  begin mtr = 1'b1; rw = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; aop = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin sa = 1'b1; sb = 2'b10; end
      10: begin rw = 1'b1; end
      11: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mw, mtr, irw, rw, rd, sa, sb, aop, il};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in that cycle
  task automatic applyStimulus(input logic rs, input logic [5:0] o, input logic mr,
                               input int es, input logic eIll, input int ec);
    expEntry_t e;
    reset    = rs;
    op       = o;
    memReady = mr;
    e.st  = rs ? 0 : es;
    e.ctl = rs ? 17'd0 : expCtrl(es, mr, eIll);
    e.cnt = ec;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input expEntry_t e);
    logic [16:0] act;
    act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, MemToReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, illegal};
    totalChecks++;
    if (state !== e.st[3:0]) begin
      badChecks++;
      $display("[TB] FAIL state: got %0d want %0d at %0t", state, e.st, $time);
    end
    totalChecks++;
    if (act !== e.ctl) begin
      badChecks++;
      $display("[TB] FAIL strobes(state %0d): got %b want %b at %0t", e.st, act, e.ctl, $time);
    end
    totalChecks++;
    if (instrCount !== e.cnt) begin
      badChecks++;
      $display("[TB] FAIL instrCount: got %0d want %0d at %0t", instrCount, e.cnt, $time);
    end
    totalChecks++;
    if (w2instrCount !== e.cnt[1:0]) begin
      badChecks++;
      $display("[TB] FAIL instrCount2bit: got %0d want %0d at %0t", w2instrCount, e.cnt[1:0], $time);
    end
  endtask

  // Monitor: compare one queued expectation on each falling edge
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JJ = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Directed instruction sequence
  initial begin
    reset = 1'b1; op = LW; memReady = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, LW, 1'b1, 0, 1'b0, 0);
    // lw: 0,1,2,3,4
    applyStimulus(1'b0, LW, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, LW, 1'b1, 1, 1'b0, 0);
    applyStimulus(1'b0, LW, 1'b1, 2, 1'b0, 0);
    applyStimulus(1'b0, LW, 1'b1, 3, 1'b0, 0);
    applyStimulus(1'b0, LW, 1'b1, 4, 1'b0, 0);
    // sw with two stalled cycles in MEMWR
    applyStimulus(1'b0, SW, 1'b1, 0, 1'b0, 1);
    applyStimulus(1'b0, SW, 1'b1, 1, 1'b0, 1);
    applyStimulus(1'b0, SW, 1'b1, 2, 1'b0, 1);
    applyStimulus(1'b0, SW, 1'b0, 5, 1'b0, 1);
    applyStimulus(1'b0, SW, 1'b0, 5, 1'b0, 1);
    applyStimulus(1'b0, SW, 1'b1, 5, 1'b0, 1);
    // FETCH stalled for 4 cycles, then addi
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, AD, 1'b0, 0, 1'b0, 2);
    applyStimulus(1'b0, AD, 1'b1, 0, 1'b0, 2);
    applyStimulus(1'b0, AD, 1'b1, 1, 1'b0, 2);
    applyStimulus(1'b0, AD, 1'b1, 9, 1'b0, 2);
    applyStimulus(1'b0, AD, 1'b1, 10, 1'b0, 2);
    // beq then j
    applyStimulus(1'b0, BQ, 1'b1, 0, 1'b0, 3);
    applyStimulus(1'b0, BQ, 1'b1, 1, 1'b0, 3);
    applyStimulus(1'b0, BQ, 1'b1, 8, 1'b0, 3);
    applyStimulus(1'b0, JJ, 1'b1, 0, 1'b0, 4);
    applyStimulus(1'b0, JJ, 1'b1, 1, 1'b0, 4);
    applyStimulus(1'b0, JJ, 1'b1, 11, 1'b0, 4);
    // illegal opcode
    applyStimulus(1'b0, BAD, 1'b1, 0, 1'b0, 5);
    applyStimulus(1'b0, BAD, 1'b1, 1, 1'b1, 5);
    // R-type interrupted by reset while in RTYPEEX
    applyStimulus(1'b0, RT, 1'b1, 0, 1'b0, 5);
    applyStimulus(1'b0, RT, 1'b1, 1, 1'b0, 5);
    applyStimulus(1'b1, RT, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b1, RT, 1'b1, 0, 1'b0, 0);
    // complete R-type after reset
    applyStimulus(1'b0, RT, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, RT, 1'b1, 1, 1'b0, 0);
    applyStimulus(1'b0, RT, 1'b1, 6, 1'b0, 0);
    applyStimulus(1'b0, RT, 1'b1, 7, 1'b0, 0);
    applyStimulus(1'b0, RT, 1'b1, 0, 1'b0, 1);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      badChecks++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
